// File: rtl/serial_adder_seq.sv
// serial_adder_seq
//   Bit-serial adder sequencer around an external gate-level full adder.
//   Operands are shifted LSB-first into the full adder, one bit per clock.
//   The carry is registered back into fa_ci, and the sum word is assembled
//   from fa_s. A built-in golden check flags any full-adder output that
//   disagrees with the expected sum/carry (sticky err).
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start           begin an addition (accepted only when idle or done)
//   a, b, cin       operands and carry-in, captured on an accepted start
//   fa_i0/i1/ci     drive the external full adder (zero outside RUN)
//   fa_s, fa_co     full-adder outputs, sampled on the advancing edge
//   sum, cout       result, valid from done until the next accepted start
//   busy            high for the WIDTH cycles of RUN
//   done            one-cycle pulse when the result becomes valid
//   err             sticky full-adder mismatch flag
//
// state | meaning
// ------+---------------------------------------------------
// IDLE  | waiting for start; fa_* driven low
// RUN   | one operand bit per cycle through the full adder
// DONE  | result valid, done pulse; start here runs back-to-back

module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_i0,
  output logic             fa_i1,
  output logic             fa_ci,
  input  logic             fa_s,
  input  logic             fa_co,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             cout_q;
  logic             err_q;

  logic             accept;
  logic             mismatch;
  logic             exp_s;
  logic             exp_co;

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    fa_i0    = 1'b0;
    fa_i1    = 1'b0;
    fa_ci    = 1'b0;
    exp_s    = 1'b0;
    exp_co   = 1'b0;
    mismatch = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        fa_i0    = a_sh[0];
        fa_i1    = b_sh[0];
        fa_ci    = carry_q;
        exp_s    = a_sh[0] ^ b_sh[0] ^ carry_q;
        exp_co   = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry_q) | (b_sh[0] & carry_q);
        mismatch = (fa_s != exp_s) || (fa_co != exp_co);
        if (cnt == CNT_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_sh    <= a;
        b_sh    <= b;
        carry_q <= cin;
        cnt     <= '0;
        sum_sh  <= '0;
        cout_q  <= 1'b0;
        err_q   <= 1'b0;
      end else if (state_q == S_RUN) begin
        sum_sh  <= {fa_s, sum_sh[WIDTH-1:1]};
        a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
        b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
        carry_q <= fa_co;
        // cnt parks on its last value so it never wraps inside an operation
        if (cnt == CNT_LAST) begin
          cout_q <= fa_co;
        end else begin
          cnt <= cnt + 1'b1;
        end
        if (mismatch) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign sum  = sum_sh;
  assign cout = cout_q;
  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign err  = err_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
`timescale 1ns/1ps

module tb_serial_adder_seq;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         fa_i0;
  logic         fa_i1;
  logic         fa_ci;
  logic         fa_s;
  logic         fa_co;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
  logic         done;
  logic         err;

  bit           fault_s0;
  bit           chk_en;
  int           n_checks;
  int           n_errors;

  serial_adder_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .fa_i0 (fa_i0),
    .fa_i1 (fa_i1),
    .fa_ci (fa_ci),
    .fa_s  (fa_s),
    .fa_co (fa_co),
    .sum   (sum),
    .cout  (cout),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  // Stand-in for the external full-adder netlist, with optional stuck-at-0 on s
  assign fa_s  = fault_s0 ? 1'b0 : (fa_i0 ^ fa_i1 ^ fa_ci);
  assign fa_co = (fa_i0 & fa_i1) | (fa_i0 & fa_ci) | (fa_i1 & fa_ci);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Carry entering bit i of x + y + c, from plain arithmetic on the low bits
  function automatic logic carry_into(input logic [W-1:0] x, input logic [W-1:0] y,
                                      input logic c, input int i);
    logic [W:0]   t;
    logic [W-1:0] mask;
    mask = (W'(1) << i) - W'(1);
    t = {1'b0, x & mask} + {1'b0, y & mask} + {{W{1'b0}}, c};
    return t[i];
  endfunction

  // Model: phase 0 = idle, 1..W = bit phase-1 in flight, W+1 = result cycle
  int           phase;
  logic [W-1:0] ma, mb, m_acc, m_sum;
  logic         mcin, m_cout, m_err;

  always @(posedge clk) begin
    int         i;
    logic       s_true, s_fa;
    logic [W:0] full;
    if (rst) begin
      phase  = 0;
      m_sum  = '0;
      m_cout = 1'b0;
      m_err  = 1'b0;
    end else if (start && (phase == 0 || phase == W + 1)) begin
      ma     = a;
      mb     = b;
      mcin   = cin;
      m_acc  = '0;
      m_sum  = '0;
      m_cout = 1'b0;
      m_err  = 1'b0;
      phase  = 1;
    end else if (phase >= 1 && phase <= W) begin
      i      = phase - 1;
      s_true = ma[i] ^ mb[i] ^ carry_into(ma, mb, mcin, i);
      s_fa   = fault_s0 ? 1'b0 : s_true;
      if (s_fa != s_true) m_err = 1'b1;
      m_acc[i] = s_fa;
      if (phase == W) begin
        full   = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mcin};
        m_sum  = m_acc;
        m_cout = full[W];
      end
      phase++;
    end else if (phase == W + 1) begin
      phase = 0;
    end
  end

  always @(negedge clk) begin
    int i;
    if (chk_en) begin
      check("busy", 32'(busy), 32'(phase >= 1 && phase <= W));
      check("done", 32'(done), 32'(phase == W + 1));
      check("err", 32'(err), 32'(m_err));
      if (phase >= 1 && phase <= W) begin
        i = phase - 1;
        check("fa_i0", 32'(fa_i0), 32'(ma[i]));
        check("fa_i1", 32'(fa_i1), 32'(mb[i]));
        check("fa_ci", 32'(fa_ci), 32'(carry_into(ma, mb, mcin, i)));
      end else begin
        check("fa_idle", {29'd0, fa_i0, fa_i1, fa_ci}, 32'd0);
        check("sum", 32'(sum), 32'(m_sum));
        check("cout", 32'(cout), 32'(m_cout));
      end
    end
  end

  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    start = 1'b1;
    a     = av;
    b     = bv;
    cin   = cv;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int n, output int nbusy);
    n     = 0;
    nbusy = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) nbusy++;
    end while (!done && n < 3 * W);
    check("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    int n, nb;
    n_checks = 0;
    n_errors = 0;
    chk_en   = 0;
    fault_s0 = 0;
    rst      = 1'b1;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    @(posedge clk);
    #1 chk_en = 1;
    check("rst_sum", 32'(sum), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_fa_ci", 32'(fa_ci), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: plain add, latency and busy length
    start_op(8'h5A, 8'h3C, 1'b0);
    wait_done(n, nb);
    check("t1_latency", 32'(n), 32'd9);
    check("t1_busy_len", 32'(nb), 32'd8);
    check("t1_sum", 32'(sum), 32'h96);
    check("t1_cout", 32'(cout), 32'h0);
    check("t1_err", 32'(err), 32'h0);
    @(posedge clk);
    #1;

    // 2: full ripple
    start_op(8'hFF, 8'h01, 1'b0);
    @(negedge clk);
    check("t2_ci_first", 32'(fa_ci), 32'd0);
    @(negedge clk);
    check("t2_ci_second", 32'(fa_ci), 32'd1);
    wait_done(n, nb);
    check("t2_latency", 32'(n), 32'd7);
    check("t2_sum", 32'(sum), 32'h00);
    check("t2_cout", 32'(cout), 32'h1);
    @(posedge clk);
    #1;

    // 3: all ones with carry-in, then back-to-back from DONE
    start_op(8'hFF, 8'hFF, 1'b1);
    wait_done(n, nb);
    check("t3a_sum", 32'(sum), 32'hFF);
    check("t3a_cout", 32'(cout), 32'h1);
    start_op(8'h01, 8'h01, 1'b0);
    check("t3_no_gap", 32'(busy), 32'd1);
    check("t3_cleared_sum", 32'(sum), 32'h0);
    wait_done(n, nb);
    check("t3b_latency", 32'(n), 32'd9);
    check("t3b_sum", 32'(sum), 32'h02);
    check("t3b_cout", 32'(cout), 32'h0);
    @(posedge clk);
    #1;

    // 4: reset in the 4th RUN cycle
    start_op(8'hAA, 8'h55, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("t4_busy", 32'(busy), 32'h0);
    check("t4_sum", 32'(sum), 32'h0);
    check("t4_cout", 32'(cout), 32'h0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("t4_no_done", 32'(done), 32'h0);
    end
    #1;
    start_op(8'hAA, 8'h55, 1'b0);
    wait_done(n, nb);
    check("t4_sum_after", 32'(sum), 32'hFF);
    check("t4_cout_after", 32'(cout), 32'h0);
    @(posedge clk);
    #1;

    // 5: start held through RUN with changing operands
    start = 1'b1;
    a     = 8'h12;
    b     = 8'h34;
    cin   = 1'b1;
    @(posedge clk);
    for (int k = 0; k < W; k++) begin
      #1;
      a   = 8'($urandom);
      b   = 8'($urandom);
      cin = ~cin;
      @(posedge clk);
    end
    #1 start = 1'b0;
    check("t5_done", 32'(done), 32'h1);
    check("t5_sum", 32'(sum), 32'h47);
    check("t5_cout", 32'(cout), 32'h0);
    @(posedge clk);
    #1;
    check("t5_idle", 32'(busy), 32'h0);

    // 6: stuck-at-0 on s
    fault_s0 = 1;
    start_op(8'h01, 8'h00, 1'b0);
    @(negedge clk);
    check("t6_err_first", 32'(err), 32'h0);
    @(negedge clk);
    check("t6_err_set", 32'(err), 32'h1);
    wait_done(n, nb);
    check("t6_sum", 32'(sum), 32'h00);
    check("t6_err_done", 32'(err), 32'h1);
    @(posedge clk);
    #1;
    check("t6_err_hold", 32'(err), 32'h1);
    fault_s0 = 0;
    start_op(8'h03, 8'h04, 1'b0);
    @(negedge clk);
    check("t6_err_clear", 32'(err), 32'h0);
    wait_done(n, nb);
    check("t6_sum_clean", 32'(sum), 32'h07);
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
